// File: rtl/wb_scoreboard_pkg.sv
// Shared types and constants for the writeback/hazard block.
//   XLEN        : register data width
//   REG_ADDR_W  : register address width (32 architectural registers)
//   wb_entry_t  : one writeback queue entry {rd, data}
//   X0          : hardwired-zero register address
package wb_scoreboard_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t X0 = '0;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Dual-push, single-pop circular writeback queue.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   push_first / first_entry    : older push of the cycle (lands at the tail)
//   push_second / second_entry  : younger push of the cycle (lands after first)
//   pop                         : retire the head when non-empty
//   slots / live                : every storage slot and whether it holds a queued entry
//   head, count, empty          : head entry, occupancy, empty flag
// The caller guarantees there is room for the pushes it asserts.
module wb_queue
  import wb_scoreboard_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_first,
  input  wb_entry_t        first_entry,
  input  logic             push_second,
  input  wb_entry_t        second_entry,
  input  logic             pop,
  output wb_entry_t        slots [DEPTH],
  output logic [DEPTH-1:0] live,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] second_ptr;
  logic [PTR_W-1:0] offset;
  logic             do_pop;

  assign empty      = (count == '0);
  assign do_pop     = pop && !empty;
  assign head       = mem[rd_ptr];
  // The younger push slides down one slot only if the older one is present.
  assign second_ptr = wr_ptr + PTR_W'(push_first);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(do_pop);
      wr_ptr <= wr_ptr + PTR_W'(push_first) + PTR_W'(push_second);
      count  <= count + CNT_W'(push_first) + CNT_W'(push_second) - CNT_W'(do_pop);
    end
  end

  // NOTE: the data storage is deliberately left unreset; the live mask and
  // count make stale contents invisible, so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (push_first)  mem[wr_ptr]     <= first_entry;
    if (push_second) mem[second_ptr] <= second_entry;
  end

  // A slot is live when its distance from the head (mod DEPTH) is below count.
  always_comb begin
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slots[i] = mem[i];
      offset   = PTR_W'(i) - rd_ptr;
      live[i]  = ({1'b0, offset} < count);
    end
  end

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback and hazard block: sole owner of the register bank write port.
// Queues ALU and load results, retires one per cycle, tracks per-register
// busy bits and forwards queued results to the two operand ports.
// Ports:
//   wb_clk, wb_rst                  : clock, synchronous active-high reset
//   wb_issue_valid/rd/rs1/rs2       : instruction presented by decode
//   wb_issue_stall                  : decode must hold the instruction
//   wb_alu_valid/rd/data            : ALU result source
//   wb_ld_valid/rd/data             : load result source
//   wb_res_ready                    : both sources may push this cycle
//   wb_rf_rd_addr_1/2, wb_rf_rd_data_1/2 : register bank read ports
//   wb_op_1/2                       : forwarded operand values
//   wb_reg_wr_en/addr, wb_reg_in    : register bank write port
module wb_scoreboard
  import wb_scoreboard_pkg::wb_entry_t;
  import wb_scoreboard_pkg::reg_addr_t;
  import wb_scoreboard_pkg::X0;
  import wb_scoreboard_pkg::NUM_REGS;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = wb_scoreboard_pkg::XLEN,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic            wb_issue_valid,
  input  logic [4:0]      wb_issue_rd,
  input  logic [4:0]      wb_issue_rs1,
  input  logic [4:0]      wb_issue_rs2,
  output logic            wb_issue_stall,
  input  logic            wb_alu_valid,
  input  logic [4:0]      wb_alu_rd,
  input  logic [XLEN-1:0] wb_alu_data,
  input  logic            wb_ld_valid,
  input  logic [4:0]      wb_ld_rd,
  input  logic [XLEN-1:0] wb_ld_data,
  output logic            wb_res_ready,
  output logic [4:0]      wb_rf_rd_addr_1,
  output logic [4:0]      wb_rf_rd_addr_2,
  input  logic [XLEN-1:0] wb_rf_rd_data_1,
  input  logic [XLEN-1:0] wb_rf_rd_data_2,
  output logic [XLEN-1:0] wb_op_1,
  output logic [XLEN-1:0] wb_op_2,
  output logic            wb_reg_wr_en,
  output logic [4:0]      wb_reg_wr_addr,
  output logic [XLEN-1:0] wb_reg_in
);

  wb_entry_t             slots [DEPTH];
  logic [DEPTH-1:0]      live;
  wb_entry_t             head;
  logic [CNT_W-1:0]      count;
  logic                  empty;

  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic                  push_ld;
  logic                  push_alu;
  logic                  hit_1, hit_2;
  logic                  dup_1, dup_2;
  logic [XLEN-1:0]       fwd_1, fwd_2;
  logic                  waw, raw_1, raw_2;
  logic                  accept;

  // Room for two pushes is judged on the registered count alone, so the
  // same-cycle pop never has to be relied upon to avoid overflow.
  assign wb_res_ready = (count <= CNT_W'(DEPTH - 2));

  // x0 results are dropped before they can take a slot.
  assign push_ld  = wb_ld_valid  && wb_res_ready && (wb_ld_rd  != X0);
  assign push_alu = wb_alu_valid && wb_res_ready && (wb_alu_rd != X0);

  // Load is the older push of the cycle, so it retires before the ALU result.
  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (wb_clk),
    .rst          (wb_rst),
    .push_first   (push_ld),
    .first_entry  ('{rd: wb_ld_rd,  data: wb_ld_data}),
    .push_second  (push_alu),
    .second_entry ('{rd: wb_alu_rd, data: wb_alu_data}),
    .pop          (wb_reg_wr_en),
    .slots        (slots),
    .live         (live),
    .head         (head),
    .count        (count),
    .empty        (empty)
  );

  assign wb_reg_wr_en   = !empty;
  assign wb_reg_wr_addr = head.rd;
  assign wb_reg_in      = head.data;

  assign wb_rf_rd_addr_1 = wb_issue_rs1;
  assign wb_rf_rd_addr_2 = wb_issue_rs2;

  // NOTE: every output of this block gets a default before the loop, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    dup_1 = 1'b0;
    dup_2 = 1'b0;
    fwd_1 = '0;
    fwd_2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (slots[i].rd == wb_issue_rs1)) begin
        dup_1 = dup_1 | hit_1;
        hit_1 = 1'b1;
        fwd_1 = slots[i].data;
      end
      if (live[i] && (slots[i].rd == wb_issue_rs2)) begin
        dup_2 = dup_2 | hit_2;
        hit_2 = 1'b1;
        fwd_2 = slots[i].data;
      end
    end
  end

  assign wb_op_1 = (wb_issue_rs1 == X0) ? '0 : (hit_1 ? fwd_1 : wb_rf_rd_data_1);
  assign wb_op_2 = (wb_issue_rs2 == X0) ? '0 : (hit_2 ? fwd_2 : wb_rf_rd_data_2);

  // A busy source is still usable once its result sits in the queue.
  assign waw   = (wb_issue_rd  != X0) && busy_q[wb_issue_rd];
  assign raw_1 = (wb_issue_rs1 != X0) && busy_q[wb_issue_rs1] && !hit_1;
  assign raw_2 = (wb_issue_rs2 != X0) && busy_q[wb_issue_rs2] && !hit_2;

  assign wb_issue_stall = wb_issue_valid && (waw || raw_1 || raw_2);
  assign accept         = wb_issue_valid && !wb_issue_stall;

  // Clear-then-set ordering is safe: an issue to a register whose result is
  // retiring this cycle is WAW-stalled, so both never target the same bit.
  always_comb begin
    busy_d = busy_q;
    if (!empty) busy_d[head.rd] = 1'b0;
    if (accept && (wb_issue_rd != X0)) busy_d[wb_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // WAW stalling keeps each destination in at most one queue slot.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst && wb_issue_valid) begin
      assert (!(dup_1 || dup_2));
    end
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed testbench for wb_scoreboard with a register bank model.
module tb_wb_scoreboard;

  logic        wb_clk;
  logic        wb_rst;
  logic        wb_issue_valid;
  logic [4:0]  wb_issue_rd, wb_issue_rs1, wb_issue_rs2;
  logic        wb_issue_stall;
  logic        wb_alu_valid;
  logic [4:0]  wb_alu_rd;
  logic [31:0] wb_alu_data;
  logic        wb_ld_valid;
  logic [4:0]  wb_ld_rd;
  logic [31:0] wb_ld_data;
  logic        wb_res_ready;
  logic [4:0]  wb_rf_rd_addr_1, wb_rf_rd_addr_2;
  logic [31:0] wb_rf_rd_data_1, wb_rf_rd_data_2;
  logic [31:0] wb_op_1, wb_op_2;
  logic        wb_reg_wr_en;
  logic [4:0]  wb_reg_wr_addr;
  logic [31:0] wb_reg_in;

  logic [31:0] rf [32];
  logic        x0_written;
  int          checks = 0;
  int          errors = 0;

  wb_scoreboard #(.DEPTH(4), .XLEN(32)) dut (
    .wb_clk          (wb_clk),
    .wb_rst          (wb_rst),
    .wb_issue_valid  (wb_issue_valid),
    .wb_issue_rd     (wb_issue_rd),
    .wb_issue_rs1    (wb_issue_rs1),
    .wb_issue_rs2    (wb_issue_rs2),
    .wb_issue_stall  (wb_issue_stall),
    .wb_alu_valid    (wb_alu_valid),
    .wb_alu_rd       (wb_alu_rd),
    .wb_alu_data     (wb_alu_data),
    .wb_ld_valid     (wb_ld_valid),
    .wb_ld_rd        (wb_ld_rd),
    .wb_ld_data      (wb_ld_data),
    .wb_res_ready    (wb_res_ready),
    .wb_rf_rd_addr_1 (wb_rf_rd_addr_1),
    .wb_rf_rd_addr_2 (wb_rf_rd_addr_2),
    .wb_rf_rd_data_1 (wb_rf_rd_data_1),
    .wb_rf_rd_data_2 (wb_rf_rd_data_2),
    .wb_op_1         (wb_op_1),
    .wb_op_2         (wb_op_2),
    .wb_reg_wr_en    (wb_reg_wr_en),
    .wb_reg_wr_addr  (wb_reg_wr_addr),
    .wb_reg_in       (wb_reg_in)
  );

  initial wb_clk = 1'b0;
  always #10 wb_clk = ~wb_clk;

  assign wb_rf_rd_data_1 = rf[wb_rf_rd_addr_1];
  assign wb_rf_rd_data_2 = rf[wb_rf_rd_addr_2];

  task automatic idle();
    wb_issue_valid = 1'b0;
    wb_issue_rd    = '0;
    wb_issue_rs1   = '0;
    wb_issue_rs2   = '0;
    wb_alu_valid   = 1'b0;
    wb_alu_rd      = '0;
    wb_alu_data    = '0;
    wb_ld_valid    = 1'b0;
    wb_ld_rd       = '0;
    wb_ld_data     = '0;
  endtask

  // Register bank model: the write port value presented this cycle lands at
  // the coming edge.
  task automatic cyc();
    if (wb_reg_wr_en === 1'b1) begin
      rf[wb_reg_wr_addr] = wb_reg_in;
      if (wb_reg_wr_addr == 5'd0) x0_written = 1'b1;
    end
    @(posedge wb_clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    wb_rst = 1'b1;
    cyc();
    cyc();
    wb_rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    wb_rst = 1'b1;
    cyc();
    cyc();
    checks++; if (wb_reg_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b want 0", wb_reg_wr_en); end
    checks++; if (wb_res_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", wb_res_ready); end
    wb_rst = 1'b0;
    for (int r = 5; r <= 8; r++) begin
      wb_issue_valid = 1'b1;
      wb_issue_rd    = 5'(r);
      #1;
      checks++; if (wb_issue_stall !== 1'b0) begin errors++; $display("FAIL reset_issue_rd%0d got %0b want 0", r, wb_issue_stall); end
      cyc();
    end
    idle();
    wb_ld_valid = 1'b1; wb_ld_rd = 5'd5; wb_ld_data = 32'h55;
    wb_alu_valid = 1'b1; wb_alu_rd = 5'd6; wb_alu_data = 32'h66;
    cyc();
    wb_ld_rd = 5'd7; wb_ld_data = 32'h77;
    wb_alu_rd = 5'd8; wb_alu_data = 32'h88;
    #1;
    checks++; if (wb_res_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_cnt2 got %0b want 1", wb_res_ready); end
    cyc();
    idle();
    #1;
    checks++; if (wb_res_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_cnt3 got %0b want 0", wb_res_ready); end
    checks++; if (wb_reg_wr_addr !== 5'd6) begin errors++; $display("FAIL reset_head got %0d want 6", wb_reg_wr_addr); end
    wb_rst = 1'b1;
    cyc();
    wb_rst = 1'b0;
    checks++; if (wb_reg_wr_en !== 1'b0) begin errors++; $display("FAIL reset_mid_wr_en got %0b want 0", wb_reg_wr_en); end
    checks++; if (wb_res_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready got %0b want 1", wb_res_ready); end
    wb_issue_valid = 1'b1; wb_issue_rd = 5'd8; wb_issue_rs1 = 5'd6; wb_issue_rs2 = 5'd7;
    #1;
    checks++; if (wb_issue_stall !== 1'b0) begin errors++; $display("FAIL reset_busy_clear got %0b want 0", wb_issue_stall); end
    idle();
  endtask

  task automatic test_raw();
    do_reset();
    wb_issue_valid = 1'b1; wb_issue_rd = 5'd5;
    #1;
    checks++; if (wb_issue_stall !== 1'b0) begin errors++; $display("FAIL raw_producer got %0b want 0", wb_issue_stall); end
    cyc();
    wb_issue_rd = 5'd10; wb_issue_rs1 = 5'd5;
    #1;
    checks++; if (wb_issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_a got %0b want 1", wb_issue_stall); end
    cyc();
    checks++; if (wb_issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_b got %0b want 1", wb_issue_stall); end
    wb_alu_valid = 1'b1; wb_alu_rd = 5'd5; wb_alu_data = 32'h1234;
    #1;
    checks++; if (wb_issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_push got %0b want 1", wb_issue_stall); end
    cyc();
    wb_alu_valid = 1'b0;
    #1;
    checks++; if (wb_issue_stall !== 1'b0) begin errors++; $display("FAIL raw_release got %0b want 0", wb_issue_stall); end
    checks++; if (wb_op_1 !== 32'h1234) begin errors++; $display("FAIL raw_fwd got %h want 00001234", wb_op_1); end
    checks++; if (wb_reg_wr_en !== 1'b1 || wb_reg_wr_addr !== 5'd5 || wb_reg_in !== 32'h1234) begin
      errors++; $display("FAIL raw_write got en=%0b x%0d=%h want en=1 x5=00001234", wb_reg_wr_en, wb_reg_wr_addr, wb_reg_in);
    end
    cyc();
    wb_issue_valid = 1'b0;
    #1;
    checks++; if (wb_reg_wr_en !== 1'b0) begin errors++; $display("FAIL raw_drained got %0b want 0", wb_reg_wr_en); end
    checks++; if (wb_op_1 !== 32'h1234) begin errors++; $display("FAIL raw_rf_read got %h want 00001234", wb_op_1); end
    idle();
  endtask

  task automatic test_dual_push();
    do_reset();
    wb_issue_valid = 1'b1; wb_issue_rd = 5'd7;
    cyc();
    wb_issue_rd = 5'd8;
    cyc();
    wb_issue_rd = 5'd0; wb_issue_rs1 = 5'd7; wb_issue_rs2 = 5'd8;
    #1;
    checks++; if (wb_issue_stall !== 1'b1) begin errors++; $display("FAIL dual_raw got %0b want 1", wb_issue_stall); end
    wb_ld_valid = 1'b1; wb_ld_rd = 5'd7; wb_ld_data = 32'hAAAA;
    wb_alu_valid = 1'b1; wb_alu_rd = 5'd8; wb_alu_data = 32'hBBBB;
    cyc();
    wb_ld_valid = 1'b0; wb_alu_valid = 1'b0;
    #1;
    checks++; if (wb_issue_stall !== 1'b0) begin errors++; $display("FAIL dual_release got %0b want 0", wb_issue_stall); end
    checks++; if (wb_op_1 !== 32'hAAAA || wb_op_2 !== 32'hBBBB) begin
      errors++; $display("FAIL dual_fwd got %h/%h want 0000aaaa/0000bbbb", wb_op_1, wb_op_2);
    end
    checks++; if (wb_reg_wr_addr !== 5'd7 || wb_reg_in !== 32'hAAAA) begin
      errors++; $display("FAIL dual_write1 got x%0d=%h want x7=0000aaaa", wb_reg_wr_addr, wb_reg_in);
    end
    wb_issue_valid = 1'b0;
    cyc();
    checks++; if (wb_reg_wr_en !== 1'b1 || wb_reg_wr_addr !== 5'd8 || wb_reg_in !== 32'hBBBB) begin
      errors++; $display("FAIL dual_write2 got en=%0b x%0d=%h want en=1 x8=0000bbbb", wb_reg_wr_en, wb_reg_wr_addr, wb_reg_in);
    end
    wb_issue_valid = 1'b1; wb_issue_rd = 5'd7; wb_issue_rs1 = 5'd0; wb_issue_rs2 = 5'd0;
    #1;
    checks++; if (wb_issue_stall !== 1'b0) begin errors++; $display("FAIL dual_busy7_clear got %0b want 0", wb_issue_stall); end
    wb_issue_rd = 5'd8;
    #1;
    checks++; if (wb_issue_stall !== 1'b1) begin errors++; $display("FAIL dual_busy8_held got %0b want 1", wb_issue_stall); end
    wb_issue_valid = 1'b0;
    cyc();
    checks++; if (wb_reg_wr_en !== 1'b0) begin errors++; $display("FAIL dual_drained got %0b want 0", wb_reg_wr_en); end
    wb_issue_valid = 1'b1;
    #1;
    checks++; if (wb_issue_stall !== 1'b0) begin errors++; $display("FAIL dual_busy8_clear got %0b want 0", wb_issue_stall); end
    idle();
  endtask

  task automatic test_backpressure();
    bit exp_ready [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int widx = 0;
    int pairs = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      wb_ld_valid  = 1'b1; wb_ld_rd  = 5'(10 + 2 * pairs); wb_ld_data  = 32'hC0DE_0000 + 32'(2 * pairs);
      wb_alu_valid = 1'b1; wb_alu_rd = 5'(11 + 2 * pairs); wb_alu_data = 32'hC0DE_0000 + 32'(2 * pairs + 1);
      #1;
      checks++; if (wb_res_ready !== exp_ready[c]) begin errors++; $display("FAIL bp_ready_c%0d got %0b want %0b", c, wb_res_ready, exp_ready[c]); end
      if (wb_reg_wr_en === 1'b1) begin
        checks++; if (wb_reg_wr_addr !== 5'(10 + widx) || wb_reg_in !== 32'hC0DE_0000 + 32'(widx)) begin
          errors++; $display("FAIL bp_order_%0d got x%0d=%h want x%0d=%h", widx, wb_reg_wr_addr, wb_reg_in, 10 + widx, 32'hC0DE_0000 + 32'(widx));
        end
        widx++;
      end
      if (wb_res_ready === 1'b1) pairs++;
      cyc();
    end
    idle();
    for (int k = 0; k < 8; k++) begin
      #1;
      if (wb_reg_wr_en === 1'b1) begin
        checks++; if (wb_reg_wr_addr !== 5'(10 + widx) || wb_reg_in !== 32'hC0DE_0000 + 32'(widx)) begin
          errors++; $display("FAIL bp_order_%0d got x%0d=%h want x%0d=%h", widx, wb_reg_wr_addr, wb_reg_in, 10 + widx, 32'hC0DE_0000 + 32'(widx));
        end
        widx++;
      end
      cyc();
    end
    checks++; if (pairs != 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", pairs); end
    checks++; if (widx != 8) begin errors++; $display("FAIL bp_written got %0d want 8", widx); end
  endtask

  task automatic test_waw_x0();
    do_reset();
    x0_written = 1'b0;
    wb_issue_valid = 1'b1; wb_issue_rd = 5'd9;
    #1;
    checks++; if (wb_issue_stall !== 1'b0) begin errors++; $display("FAIL waw_first got %0b want 0", wb_issue_stall); end
    checks++; if (wb_op_1 !== 32'h0 || wb_op_2 !== 32'h0) begin errors++; $display("FAIL x0_operand got %h/%h want 0/0", wb_op_1, wb_op_2); end
    cyc();
    checks++; if (wb_issue_stall !== 1'b1) begin errors++; $display("FAIL waw_stall_a got %0b want 1", wb_issue_stall); end
    cyc();
    wb_alu_valid = 1'b1; wb_alu_rd = 5'd9; wb_alu_data = 32'h9999;
    wb_ld_valid  = 1'b1; wb_ld_rd  = 5'd0; wb_ld_data  = 32'hDEAD;
    #1;
    checks++; if (wb_issue_stall !== 1'b1) begin errors++; $display("FAIL waw_stall_b got %0b want 1", wb_issue_stall); end
    cyc();
    wb_alu_valid = 1'b0; wb_ld_valid = 1'b0;
    #1;
    checks++; if (wb_issue_stall !== 1'b1) begin errors++; $display("FAIL waw_head got %0b want 1", wb_issue_stall); end
    checks++; if (wb_reg_wr_en !== 1'b1 || wb_reg_wr_addr !== 5'd9) begin
      errors++; $display("FAIL waw_write got en=%0b x%0d want en=1 x9", wb_reg_wr_en, wb_reg_wr_addr);
    end
    cyc();
    checks++; if (wb_issue_stall !== 1'b0) begin errors++; $display("FAIL waw_release got %0b want 0", wb_issue_stall); end
    checks++; if (wb_reg_wr_en !== 1'b0) begin errors++; $display("FAIL x0_dropped got %0b want 0", wb_reg_wr_en); end
    cyc();
    idle();
    checks++; if (x0_written !== 1'b0) begin errors++; $display("FAIL x0_never_written got %0b want 0", x0_written); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wb_ld_valid  = (i % 2 == 0);
      wb_alu_valid = (i % 2 == 1);
      wb_ld_rd  = 5'(i + 1); wb_ld_data  = 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
      wb_alu_rd = 5'(i + 1); wb_alu_data = 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
      cyc();
      wb_ld_valid = 1'b0; wb_alu_valid = 1'b0;
      wb_issue_rs1 = 5'(i + 1);
      #1;
      checks++; if (wb_op_1 !== 32'h5A00_0000 + 32'(i) * 32'h0001_0101 || wb_reg_wr_addr !== 5'(i + 1)) begin
        errors++; $display("FAIL wrap_fwd_%0d got x%0d op=%h want x%0d op=%h", i, wb_reg_wr_addr, wb_op_1, i + 1, 32'h5A00_0000 + 32'(i) * 32'h0001_0101);
      end
    end
    cyc();
    checks++; if (wb_reg_wr_en !== 1'b0) begin errors++; $display("FAIL wrap_drained got %0b want 0", wb_reg_wr_en); end
    for (int i = 0; i < 20; i++) begin
      wb_issue_rs1 = 5'(i + 1);
      #1;
      checks++; if (wb_op_1 !== 32'h5A00_0000 + 32'(i) * 32'h0001_0101) begin
        errors++; $display("FAIL wrap_rf_x%0d got %h want %h", i + 1, wb_op_1, 32'h5A00_0000 + 32'(i) * 32'h0001_0101);
      end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hF000_0000 + 32'(i);
    x0_written = 1'b0;
    wb_rst = 1'b1;
    idle();
    test_reset();
    test_raw();
    test_dual_push();
    test_backpressure();
    test_waw_x0();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Writeback and hazard block that sits between the execute/load paths and the register bank's single write port. It owns the only write path into the register bank. It queues completed ALU and load results in a 4-entry writeback queue and retires them one per cycle. It also keeps a per-register busy scoreboard and forwards queued results to the two read ports, stalling issue when an operand is not yet available.

## Interface
- DEPTH, 4, writeback queue entries (power of two, ≥2)
- XLEN, 32, data width
- wb_clk  in  1  clock, all state on rising edge
- wb_rst  in  1  synchronous, active-high reset
- wb_issue_valid  in  1  decode presents an instruction this cycle
- wb_issue_rd / wb_issue_rs1 / wb_issue_rs2  in  5 each  destination and sources of issuing instruction
- wb_issue_stall  out  1  instruction must be held; no state change for it
- wb_alu_valid, wb_alu_rd, wb_alu_data  in  1/5/XLEN  ALU result
- wb_ld_valid, wb_ld_rd, wb_ld_data  in  1/5/XLEN  load result
- wb_res_ready  out  1  both result sources may push this cycle
- wb_rf_rd_addr_1 / _2  out  5  = wb_issue_rs1 / wb_issue_rs2, to register bank read ports
- wb_rf_rd_data_1 / _2  in  XLEN  register bank read data (asynchronous)
- wb_op_1 / wb_op_2  out  XLEN  forwarded operand values
- wb_reg_wr_en, wb_reg_wr_addr, wb_reg_in  out  1/5/XLEN  to register bank write port

## Operation
- Busy vector busy[31:1] (x0 is never busy). An issue is accepted when wb_issue_valid & !wb_issue_stall. On acceptance with rd≠0, set busy[rd].
- Stall = valid & (WAW: rd≠0 & busy[rd]) | (RAW: for rs1 or rs2 ≠0, busy[rs] & no queue entry holds rs).
- Operand: rs==0 → 0; queue entry matches rs → entry data; else wb_rf_rd_data.
- WAW stall guarantees at most one queue entry per rd. Two matching entries is a checked error.
- wb_res_ready = (free slots ≥ 2), computed from the registered count. Pushes are ignored when not ready; sources must hold valid.
- Push order within a cycle: load, then ALU. Results with rd==0 are dropped and do not occupy a slot.
- Write port is combinational from the queue head: wb_reg_wr_en = !empty, addr/data = head. Head pops every cycle it is non-empty. At the same edge, busy[head.rd] clears.
- Simultaneous clear and set of the same rd cannot occur, because the issue is WAW-stalled.
- Push and pop in the same cycle: count = count + pushes − pop. Pointers wrap modulo DEPTH.

## Timing
- Reset values: queue empty, count 0, busy all 0, wb_reg_wr_en 0, wb_res_ready 1. wb_issue_stall and wb_op_* follow their combinational definitions.
- Reset mid-operation: queued results are discarded and all busy bits clear on the reset edge.
- Result pushed at edge N: forwardable from N, written into the register bank at edge N+1 when at head, and readable via the register bank after N+1.
- Issue accepted at edge N: busy[rd] visible from N. A dependent issue in the next cycle stalls until the result enters the queue.
- Throughput: one retirement per cycle and up to two pushes per cycle while ≥2 slots are free.

## Structure
- Shared package: XLEN, REG_ADDR_W=5, the queue entry typedef {rd[4:0], data[XLEN-1:0]}, and X0 constant.
- One sub-module is natural: wb_queue, a dual-push single-pop circular buffer that exposes all entries for forwarding compare. The scoreboard, stall logic and forward mux stay in the top level.

## Test plan
- Reset: assert wb_rst with 3 entries queued → after edge, wb_reg_wr_en=0, count 0, busy=0, wb_res_ready=1.
- RAW: issue rd=5, then issue rs1=5 → stall until ALU pushes x5=0x1234. The next cycle wb_op_1=0x1234 from the queue, and x5 is written one cycle later.
- Dual push: load x7=0xAAAA and ALU x8=0xBBBB in the same cycle → writes x7 then x8 on consecutive cycles, and busy[7], busy[8] clear in order.
- Backpressure: hold both sources valid for 6 cycles → ready drops at 3 entries, no loss, and write order matches push order.
- WAW and x0: issue rd=9 twice → second stalls until x9 retires. A result with rd=0 is never written, and rs=0 yields 0.
- Wrap: 20 alternating pushes → pointers wrap correctly and data is checked against the register bank model.
